// File: rtl/imm_pkg.sv
// Shared types and RV opcode constants for the immediate-generation stage.
package imm_pkg;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5,
        IMM_SH   = 3'd6
    } imm_type_t;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

endpackage

// File: rtl/imm_decode.sv
// Combinational RV immediate extractor: classifies the instruction and
// produces the XLEN-wide extended immediate.
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_instr,
    output logic [XLEN-1:0] o_imm,
    output imm_type_t       o_type
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;

    assign w_opcode = i_instr[6:0];
    assign w_funct3 = i_instr[14:12];

    always_comb begin
        o_imm  = '0;
        o_type = IMM_NONE;
        unique case (w_opcode)
            OP_IMM, OP_LOAD, OP_JALR: begin
                // Shift-immediates reuse OP_IMM; shamt width follows XLEN.
                if (w_opcode == OP_IMM && (w_funct3 == 3'b001 || w_funct3 == 3'b101)) begin
                    o_type = IMM_SH;
                    o_imm  = (XLEN == 64) ? XLEN'(i_instr[25:20]) : XLEN'(i_instr[24:20]);
                end else begin
                    o_type = IMM_I;
                    o_imm  = XLEN'($signed(i_instr[31:20]));
                end
            end
            OP_STORE: begin
                o_type = IMM_S;
                o_imm  = XLEN'($signed({i_instr[31:25], i_instr[11:7]}));
            end
            OP_BRANCH: begin
                o_type = IMM_B;
                o_imm  = XLEN'($signed({i_instr[31], i_instr[7], i_instr[30:25],
                                        i_instr[11:8], 1'b0}));
            end
            OP_LUI, OP_AUIPC: begin
                o_type = IMM_U;
                o_imm  = XLEN'($signed({i_instr[31:12], 12'b0}));
            end
            OP_JAL: begin
                o_type = IMM_J;
                o_imm  = XLEN'($signed({i_instr[31], i_instr[19:12], i_instr[20],
                                        i_instr[30:21], 1'b0}));
            end
            default: begin
                o_type = IMM_NONE;
                o_imm  = '0;
            end
        endcase
    end

endmodule

// File: rtl/imm_gen_stage.sv
// One-cycle immediate-generation pipeline stage with an output register
// backed by a single skid entry; decode happens before the registers.
module imm_gen_stage
    import imm_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter bit PASS_PC = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output imm_type_t       out_type,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc
);

    logic [XLEN-1:0] w_imm;
    imm_type_t       w_type;
    logic [XLEN-1:0] w_pc;
    logic            w_in_fire;
    logic            w_out_avail;
    logic            w_skid_vld_nxt;

    logic            r_in_ready;
    logic            r_out_valid;
    logic [XLEN-1:0] r_out_imm;
    imm_type_t       r_out_type;
    logic [31:0]     r_out_instr;
    logic [XLEN-1:0] r_out_pc;
    logic            r_skid_valid;
    logic [XLEN-1:0] r_skid_imm;
    imm_type_t       r_skid_type;
    logic [31:0]     r_skid_instr;
    logic [XLEN-1:0] r_skid_pc;

    imm_decode #(.XLEN(XLEN)) u_dec (
        .i_instr (in_instr),
        .o_imm   (w_imm),
        .o_type  (w_type)
    );

    assign w_pc        = PASS_PC ? in_pc : '0;
    assign w_in_fire   = in_valid && r_in_ready && !flush;
    assign w_out_avail = !r_out_valid || out_ready;
    // Skid keeps a beat only if the output stays blocked, or refills behind a drain.
    assign w_skid_vld_nxt = flush       ? 1'b0 :
                            w_out_avail ? (r_skid_valid && w_in_fire) :
                                          (r_skid_valid || w_in_fire);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_imm    <= '0;
            r_out_type   <= IMM_NONE;
            r_out_instr  <= '0;
            r_out_pc     <= '0;
            r_skid_valid <= 1'b0;
            r_skid_imm   <= '0;
            r_skid_type  <= IMM_NONE;
            r_skid_instr <= '0;
            r_skid_pc    <= '0;
        end else begin
            r_in_ready   <= !w_skid_vld_nxt;
            r_skid_valid <= w_skid_vld_nxt;
            if (flush) begin
                r_out_valid <= 1'b0;
            end else if (w_out_avail) begin
                if (r_skid_valid) begin
                    r_out_valid <= 1'b1;
                    r_out_imm   <= r_skid_imm;
                    r_out_type  <= r_skid_type;
                    r_out_instr <= r_skid_instr;
                    r_out_pc    <= r_skid_pc;
                end else if (w_in_fire) begin
                    r_out_valid <= 1'b1;
                    r_out_imm   <= w_imm;
                    r_out_type  <= w_type;
                    r_out_instr <= in_instr;
                    r_out_pc    <= w_pc;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end
            if (!flush && w_in_fire && (r_skid_valid || !w_out_avail)) begin
                r_skid_imm   <= w_imm;
                r_skid_type  <= w_type;
                r_skid_instr <= in_instr;
                r_skid_pc    <= w_pc;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_imm   = r_out_imm;
    assign out_type  = r_out_type;
    assign out_instr = r_out_instr;
    assign out_pc    = r_out_pc;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed bench: an XLEN=32 (PC passed) and an XLEN=64 (PC tied off)
// instance share the same stimulus.
module tb_imm_gen_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc32 = '0;
    logic [63:0] in_pc64 = '0;
    logic        out_ready = 1'b1;

    logic        rdy32, vld32, rdy64, vld64;
    logic [31:0] imm32, ins32, pc32;
    logic [63:0] imm64, pc64;
    logic [31:0] ins64;
    logic [2:0]  typ32, typ64;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    imm_gen_stage #(.XLEN(32), .PASS_PC(1'b1)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy32), .in_instr(in_instr), .in_pc(in_pc32),
        .out_valid(vld32), .out_ready(out_ready), .out_imm(imm32), .out_type(typ32),
        .out_instr(ins32), .out_pc(pc32)
    );

    imm_gen_stage #(.XLEN(64), .PASS_PC(1'b0)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy64), .in_instr(in_instr), .in_pc(in_pc64),
        .out_valid(vld64), .out_ready(out_ready), .out_imm(imm64), .out_type(typ64),
        .out_instr(ins64), .out_pc(pc64)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
        in_valid = v;
        in_instr = ins;
        in_pc32  = pc;
        in_pc64  = {32'hDEAD_0000, pc};
    endtask

    task automatic chk32(input string tag, input logic [31:0] imm, input logic [2:0] typ);
        chk({tag, "_v32"}, 64'(vld32), 64'd1);
        chk({tag, "_imm32"}, 64'(imm32), 64'(imm));
        chk({tag, "_typ32"}, 64'(typ32), 64'(typ));
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_vld", 64'(vld32), 64'd0);
        chk("rst_rdy", 64'(rdy32), 64'd0);
        chk("rst_imm", imm64, 64'd0);
        chk("rst_typ", 64'(typ32), 64'd0);
        tick;
        chk("rst_hold_rdy", 64'(rdy64), 64'd0);
        #3 rst_n = 1'b1;
        chk("rel_rdy_pre", 64'(rdy32), 64'd0);
        tick;
        chk("rel_rdy", 64'(rdy32), 64'd1);
        chk("rel_vld", 64'(vld32), 64'd0);

        drive(1'b1, 32'hFFF00093, 32'h100);
        tick;
        chk32("addi_m1", 32'hFFFFFFFF, 3'd1);
        chk("addi_pc32", 64'(pc32), 64'h100);
        chk("addi_ins", 64'(ins32), 64'hFFF00093);
        chk("addi_pc64", pc64, 64'd0);
        chk("addi_imm64", imm64, 64'hFFFFFFFF_FFFFFFFF);

        drive(1'b1, 32'hFE000EE3, 32'h104);
        tick;
        chk32("beq_m4", 32'hFFFFFFFC, 3'd3);
        chk("beq_pc32", 64'(pc32), 64'h104);

        drive(1'b1, 32'h123452B7, 32'h108);
        tick;
        chk32("lui", 32'h12345000, 3'd4);
        chk("lui_imm64", imm64, 64'h0000_0000_1234_5000);

        drive(1'b1, 32'h800002B7, 32'h10C);
        tick;
        chk32("lui_neg", 32'h80000000, 3'd4);
        chk("lui_neg64", imm64, 64'hFFFFFFFF_80000000);

        drive(1'b1, 32'h03F09093, 32'h110);
        tick;
        chk32("slli", 32'd31, 3'd6);
        chk("slli_imm64", imm64, 64'd63);
        chk("slli_typ64", 64'(typ64), 64'd6);

        drive(1'b1, 32'hFE112E23, 32'h114);
        tick;
        chk32("sw_m4", 32'hFFFFFFFC, 3'd2);

        drive(1'b1, 32'h0080006F, 32'h118);
        tick;
        chk32("jal_8", 32'd8, 3'd5);

        drive(1'b1, 32'h0000007F, 32'h11C);
        tick;
        chk32("unknown", 32'd0, 3'd0);
        chk("unknown_rdy", 64'(rdy32), 64'd1);

        drive(1'b0, 32'h0, 32'h0);
        tick;
        chk("idle_vld", 64'(vld32), 64'd0);

        // Backpressure: A to output, B to skid, C refused until drain.
        out_ready = 1'b0;
        drive(1'b1, 32'h00100093, 32'h200);
        tick;
        chk32("bp_a", 32'd1, 3'd1);
        chk("bp_a_rdy", 64'(rdy32), 64'd1);
        drive(1'b1, 32'h00200093, 32'h204);
        tick;
        chk("bp_b_rdy", 64'(rdy32), 64'd0);
        chk("bp_b_hold", 64'(imm32), 64'd1);
        drive(1'b1, 32'h00300093, 32'h208);
        tick;
        chk("bp_c_rdy", 64'(rdy32), 64'd0);
        chk("bp_c_hold", 64'(imm32), 64'd1);
        chk("bp_c_hold_pc", 64'(pc32), 64'h200);
        out_ready = 1'b1;
        tick;
        chk32("bp_out_b", 32'd2, 3'd1);
        chk("bp_out_b_rdy", 64'(rdy32), 64'd1);
        tick;
        chk32("bp_out_c", 32'd3, 3'd1);
        chk("bp_out_c_pc", 64'(pc32), 64'h208);
        drive(1'b0, 32'h0, 32'h0);
        tick;
        chk("bp_nodup", 64'(vld32), 64'd0);

        // Skid full, then flush with a beat offered in the same cycle.
        out_ready = 1'b0;
        drive(1'b1, 32'h00500093, 32'h300);
        tick;
        drive(1'b1, 32'h00600093, 32'h304);
        tick;
        chk("fl_full_rdy", 64'(rdy32), 64'd0);
        flush = 1'b1;
        drive(1'b1, 32'h00700093, 32'h308);
        tick;
        chk("fl_vld", 64'(vld32), 64'd0);
        chk("fl_rdy", 64'(rdy32), 64'd1);
        flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 32'h0, 32'h0);
        tick;
        chk("fl_dropped", 64'(vld32), 64'd0);

        // Async reset between edges with two beats held.
        out_ready = 1'b0;
        drive(1'b1, 32'h00800093, 32'h400);
        tick;
        drive(1'b1, 32'h00900093, 32'h404);
        tick;
        drive(1'b0, 32'h0, 32'h0);
        chk("ar_full_vld", 64'(vld64), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_vld", 64'(vld32), 64'd0);
        chk("ar_rdy", 64'(rdy32), 64'd0);
        chk("ar_imm", 64'(imm32), 64'd0);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        tick;
        chk("ar_rel_rdy", 64'(rdy32), 64'd1);
        chk("ar_rel_vld", 64'(vld32), 64'd0);
        tick;
        chk("ar_no_ghost", 64'(vld64), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/imm_gen_stage.md
IMM_GEN_STAGE -- requirements
Module: imm_gen_stage

Interface
REQ-001 Parameter XLEN, default 32: datapath width; legal values 32 or 64.
REQ-002 Parameter PASS_PC, default 1: 1 = carry pc_in through to pc_out; 0 = pc_out tied to 0.
REQ-003 Port clk  input  1: single clock; all state updates on the rising edge.
REQ-004 Port rst_n  input  1: reset, asynchronous, active-low.
REQ-005 Port flush  input  1: synchronous pipeline flush.
REQ-006 Port in_valid  input  1: upstream beat valid.
REQ-007 Port in_ready  output  1: stage accepts a beat this cycle.
REQ-008 Port in_instr  input  32: RV instruction word.
REQ-009 Port in_pc  input  XLEN: PC of in_instr.
REQ-010 Port out_valid  output  1: output beat valid.
REQ-011 Port out_ready  input  1: downstream accepts the output beat.
REQ-012 Port out_imm  output  XLEN: extended immediate.
REQ-013 Port out_type  output  3: immediate class, imm_type_t.
REQ-014 Port out_instr  output  32 and out_pc  output  XLEN: passthrough of the beat's instruction and PC.

Function
REQ-015 The decode SHALL select the class by opcode: 0010011/0000011/1100111 -> I; 0100011 -> S; 1100011 -> B; 0110111/0010111 -> U; 1101111 -> J; anything else -> NONE with imm 0.
REQ-016 For opcode 0010011 with funct3 001 or 101, the class SHALL be SH: imm zero-extended shamt, instr[25:20] when XLEN=64, instr[24:20] when XLEN=32.
REQ-017 The I/S/B/J classes SHALL use standard RV bit placement, sign-extended from instr[31] to XLEN; B and J SHALL have bit0=0.
REQ-018 The U class SHALL be {instr[31:12],12'b0} sign-extended from bit 31 to XLEN.
REQ-019 A beat SHALL transfer on the input when in_valid&&in_ready, and on the output when out_valid&&out_ready.
REQ-020 Latency SHALL be 1 cycle: a beat accepted in cycle N appears on out_* in N+1 if the output register is free or draining.
REQ-021 Storage SHALL be an output register plus a one-entry skid register, giving 2 entries total.
REQ-022 If the output register is occupied and not draining, an accepted beat SHALL go to the skid register.
REQ-023 in_ready SHALL be registered and equal to !skid_valid after the edge.
REQ-024 When the output drains while skid holds a beat, the skid beat SHALL move to the output register in that edge.
REQ-025 A beat accepted in the same edge SHALL land in the skid register.
REQ-026 Ordering SHALL be strict FIFO, with no loss and no duplication.
REQ-027 out_* SHALL hold stable while out_valid&&!out_ready.
REQ-028 flush SHALL clear out_valid and skid_valid at the edge and SHALL set in_ready=1.
REQ-029 A beat presented in the flush cycle SHALL be dropped, and flush SHALL win over a simultaneous accept.
REQ-030 Unknown opcodes SHALL still flow through the pipeline with type NONE; the stage SHALL NOT stall on them.

Reset
REQ-031 While rst_n=0, out_valid, skid_valid and in_ready SHALL be 0, and out_imm, out_type, out_instr and out_pc SHALL be 0.
REQ-032 in_ready SHALL rise at the first clk edge after rst_n deasserts.
REQ-033 Reset asserted mid-transfer SHALL discard all held beats immediately, without waiting for clk.

Structure
REQ-034 Package imm_pkg SHALL hold imm_type_t (NONE=0, I=1, S=2, B=3, U=4, J=5, SH=6) and the opcode localparams.
REQ-035 Sub-module imm_decode (combinational, XLEN-parametrised, instr -> imm, type) SHALL be instantiated once, on the input side, so that the registers hold decoded results.

Verification
REQ-036 XLEN=32: instr 0xFFF00093 -> next cycle out_imm=0xFFFFFFFF, out_type=I.
REQ-037 instr 0xFE000EE3 (beq offset -4) -> out_imm=0xFFFFFFFC, out_type=B; instr 0x123452B7 -> out_imm=0x12345000, out_type=U.
REQ-038 XLEN=64: instr 0x800002B7 -> out_imm=0xFFFFFFFF80000000; instr 0x03F09093 -> out_imm=63, out_type=SH (XLEN=32 gives 31).
REQ-039 Backpressure: out_ready=0, three beats offered -> beats 1 and 2 accepted and in_ready=0; out_ready=1 -> outputs in order 1, 2, then 3 accepted, no duplicates.
REQ-040 Skid full plus flush, with in_valid=1 in the same cycle -> next cycle out_valid=0, in_ready=1, and the flush-cycle beat never appears.
REQ-041 rst_n pulsed low between clk edges with 2 beats held -> out_valid=0 and in_ready=0 immediately; in_ready=1 one edge after release.
